// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle MIPS-subset controller
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MADDR  = 4'd2,
        S_MRD    = 4'd3,
        S_MWB    = 4'd4,
        S_MWR    = 4'd5,
        S_EXE    = 4'd6,
        S_ALUWB  = 4'd7,
        S_BR     = 4'd8,
        S_JMP    = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_OR  = 3'd2,
        ALU_LUI = 3'd3,
        ALU_SLL = 3'd4
    } aluctr_t;

    typedef enum logic [1:0] {
        WA_RD = 2'd0,
        WA_RT = 2'd1,
        WA_RA = 2'd2
    } wactr_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MDR = 2'd1,
        WD_PC  = 2'd2
    } wdctr_t;

    typedef enum logic [1:0] {
        BR_PC4    = 2'd0,
        BR_BRANCH = 2'd1,
        BR_JUMP   = 2'd2,
        BR_RS     = 2'd3
    } brctr_t;

    typedef enum logic [2:0] {
        CLS_ILL = 3'd0,
        CLS_MEM = 3'd1,
        CLS_ALU = 3'd2,
        CLS_BR  = 3'd3,
        CLS_JMP = 3'd4
    } iclass_t;

endpackage

// File: rtl/mc_if.sv
// rtl/mc_if.sv - controller <-> datapath control bundle
interface mc_if;
    logic [5:0] op;
    logic [5:0] f;
    logic       zero;
    logic       pcwrite;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic [1:0] wactr;
    logic [1:0] wdctr;
    logic       extctr;
    logic       bctr;
    logic [2:0] aluctr;
    logic [1:0] brctr;
    logic [3:0] state;

    modport master (
        input  op, f, zero,
        output pcwrite, irwrite, iord, memwrite, regwrite,
        output wactr, wdctr, extctr, bctr, aluctr, brctr, state
    );

    modport slave (
        output op, f, zero,
        input  pcwrite, irwrite, iord, memwrite, regwrite,
        input  wactr, wdctr, extctr, bctr, aluctr, brctr, state
    );
endinterface

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - op/funct to instruction class and per-instruction ALU setup
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] f,
    output iclass_t    cls,
    output logic       is_lw,
    output logic       is_jal,
    output logic       is_jr,
    output logic       is_rtype,
    output aluctr_t    alu,
    output logic       use_imm,
    output logic       sign_ext
);
    always_comb begin
        cls      = CLS_ILL;
        is_lw    = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        is_rtype = (op == OP_RTYPE);
        alu      = ALU_ADD;
        use_imm  = 1'b0;
        sign_ext = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (f)
                    FN_ADDU: cls = CLS_ALU;
                    FN_SUBU: begin cls = CLS_ALU; alu = ALU_SUB; end
                    FN_SLL:  begin cls = CLS_ALU; alu = ALU_SLL; end
                    FN_JR:   begin cls = CLS_JMP; is_jr = 1'b1; end
                    default: cls = CLS_ILL;
                endcase
            end
            OP_LW:    begin cls = CLS_MEM; is_lw = 1'b1; end
            OP_SW:    cls = CLS_MEM;
            OP_ORI:   begin cls = CLS_ALU; alu = ALU_OR; use_imm = 1'b1; end
            OP_LUI:   begin cls = CLS_ALU; alu = ALU_LUI; use_imm = 1'b1; end
            OP_ADDIU: begin cls = CLS_ALU; use_imm = 1'b1; sign_ext = 1'b1; end
            OP_BEQ:   cls = CLS_BR;
            OP_J:     cls = CLS_JMP;
            OP_JAL:   begin cls = CLS_JMP; is_jal = 1'b1; end
            default:  cls = CLS_ILL;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle control FSM driving the shared-ALU datapath
module mc_controller
    import mc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    mc_if.master bus
);
    state_t  st;
    iclass_t cls;
    aluctr_t dec_alu;
    logic    is_lw, is_jal, is_jr, is_rtype, use_imm, sign_ext;
    logic    pcw, irw, memw, regw;

    mc_decode u_decode (
        .op       (bus.op),
        .f        (bus.f),
        .cls      (cls),
        .is_lw    (is_lw),
        .is_jal   (is_jal),
        .is_jr    (is_jr),
        .is_rtype (is_rtype),
        .alu      (dec_alu),
        .use_imm  (use_imm),
        .sign_ext (sign_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= S_FETCH;
        end else begin
            case (st)
                S_FETCH:  st <= S_DECODE;
                S_DECODE: begin
                    case (cls)
                        CLS_MEM: st <= S_MADDR;
                        CLS_ALU: st <= S_EXE;
                        CLS_BR:  st <= S_BR;
                        CLS_JMP: st <= S_JMP;
                        default: st <= S_FETCH;
                    endcase
                end
                S_MADDR:  st <= is_lw ? S_MRD : S_MWR;
                S_MRD:    st <= S_MWB;
                S_EXE:    st <= S_ALUWB;
                default:  st <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcw         = 1'b0;
        irw         = 1'b0;
        memw        = 1'b0;
        regw        = 1'b0;
        bus.iord    = 1'b0;
        bus.wactr   = WA_RD;
        bus.wdctr   = WD_ALU;
        bus.extctr  = 1'b0;
        bus.bctr    = 1'b0;
        bus.aluctr  = ALU_ADD;
        bus.brctr   = BR_PC4;
        case (st)
            S_FETCH: begin
                irw = 1'b1;
                pcw = 1'b1;
            end
            S_MADDR: begin
                bus.bctr   = 1'b1;
                bus.extctr = 1'b1;
            end
            S_MRD: bus.iord = 1'b1;
            S_MWB: begin
                regw      = 1'b1;
                bus.wactr = WA_RT;
                bus.wdctr = WD_MDR;
            end
            S_MWR: begin
                bus.iord = 1'b1;
                memw     = 1'b1;
            end
            S_EXE: begin
                bus.aluctr = dec_alu;
                bus.bctr   = use_imm;
                bus.extctr = sign_ext;
            end
            S_ALUWB: begin
                regw      = 1'b1;
                bus.wactr = is_rtype ? WA_RD : WA_RT;
            end
            S_BR: begin
                // Branch decision comes straight from this cycle's compare.
                bus.aluctr = ALU_SUB;
                bus.brctr  = BR_BRANCH;
                pcw        = bus.zero;
            end
            S_JMP: begin
                pcw       = 1'b1;
                bus.brctr = is_jr ? BR_RS : BR_JUMP;
                if (is_jal) begin
                    regw      = 1'b1;
                    bus.wactr = WA_RA;
                    bus.wdctr = WD_PC;
                end
            end
            default: ;
        endcase
    end

    // Enables are suppressed during reset so an aborted instruction leaves no side effects.
    assign bus.pcwrite  = pcw  & ~reset;
    assign bus.irwrite  = irw  & ~reset;
    assign bus.memwrite = memw & ~reset;
    assign bus.regwrite = regw & ~reset;
    assign bus.state    = st;
endmodule
